// File: rtl/i2c_req_arbiter_if.sv
// Requester, response, bridge and status signals of the two-port I2C request arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface i2c_req_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [23:0] req0_cmd;
    logic        rsp0_valid;
    logic        rsp0_ack;
    logic [7:0]  rsp0_rdata;
    logic        rsp0_timeout;

    logic        req1_valid;
    logic        req1_ready;
    logic [23:0] req1_cmd;
    logic        rsp1_valid;
    logic        rsp1_ack;
    logic [7:0]  rsp1_rdata;
    logic        rsp1_timeout;

    logic [23:0] addr_data_out;
    logic        valid_addr_data_out;
    logic        I2C_trigger;
    logic        valid_data_ack;
    logic        valid_data_ack_valid;
    logic [7:0]  rdata_out;
    logic        rdata_out_valid;
    logic        PENDING_WR;
    logic        PENDING_RD;

    logic        busy;
    logic        grant_id;

    modport slave (
        input  req0_valid, req0_cmd, req1_valid, req1_cmd,
        input  valid_data_ack, valid_data_ack_valid, rdata_out, rdata_out_valid,
        input  PENDING_WR, PENDING_RD,
        output req0_ready, rsp0_valid, rsp0_ack, rsp0_rdata, rsp0_timeout,
        output req1_ready, rsp1_valid, rsp1_ack, rsp1_rdata, rsp1_timeout,
        output addr_data_out, valid_addr_data_out, I2C_trigger, busy, grant_id
    );

    modport master (
        output req0_valid, req0_cmd, req1_valid, req1_cmd,
        output valid_data_ack, valid_data_ack_valid, rdata_out, rdata_out_valid,
        output PENDING_WR, PENDING_RD,
        input  req0_ready, rsp0_valid, rsp0_ack, rsp0_rdata, rsp0_timeout,
        input  req1_ready, rsp1_valid, rsp1_ack, rsp1_rdata, rsp1_timeout,
        input  addr_data_out, valid_addr_data_out, I2C_trigger, busy, grant_id
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C bridge between two requesters; runs one
// transaction at a time through LOAD/TRIG/WAIT/RESP with a completion timeout.
module i2c_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    i2c_req_arbiter_if.slave   bus
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_TRIG = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]    state_q,     state_d;
    logic          lastGrant_q, lastGrant_d;
    logic          grant_q,     grant_d;
    logic [23:0]   cmd_q,       cmd_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          ack_q,       ack_d;
    logic [7:0]    rdata_q,     rdata_d;
    logic          tmo_q,       tmo_d;

    logic idleOk;
    logic ready0;
    logic ready1;
    logic isRead;
    logic rdNack;
    logic wrDone;
    logic rdDone;
    logic rspAny;

    // Ready is offered only in IDLE with the bridge idle; on a tie the requester
    // that did not win last time is chosen.
    assign idleOk = (state_q == S_IDLE) && !bus.PENDING_WR && !bus.PENDING_RD && !reset;
    assign ready0 = idleOk && bus.req0_valid && (!bus.req1_valid || lastGrant_q);
    assign ready1 = idleOk && bus.req1_valid && (!bus.req0_valid || !lastGrant_q);

    assign isRead = cmd_q[16];
    assign wrDone = !isRead && bus.valid_data_ack_valid;
    assign rdNack = isRead && bus.valid_data_ack_valid && !bus.valid_data_ack;
    assign rdDone = isRead && bus.rdata_out_valid;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        tmo_d       = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (ready0 || ready1) begin
                    cmd_d       = ready1 ? bus.req1_cmd : bus.req0_cmd;
                    grant_d     = ready1;
                    lastGrant_d = ready1;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: state_d = S_TRIG;
            S_TRIG: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes precedence over a timeout in the same cycle;
                // a read NACK outranks read data arriving alongside it.
                if (wrDone) begin
                    ack_d   = bus.valid_data_ack;
                    rdata_d = 8'h00;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (rdNack) begin
                    ack_d   = 1'b0;
                    rdata_d = 8'h00;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (rdDone) begin
                    ack_d   = 1'b1;
                    rdata_d = bus.rdata_out;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    ack_d   = 1'b0;
                    rdata_d = 8'h00;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lastGrant_q <= 1'b1;
            grant_q     <= 1'b0;
            cmd_q       <= 24'h0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= 8'h00;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            tmo_q       <= tmo_d;
        end
    end

    assign rspAny = (state_q == S_RESP);

    assign bus.req0_ready          = ready0;
    assign bus.req1_ready          = ready1;
    assign bus.addr_data_out       = cmd_q;
    assign bus.valid_addr_data_out = (state_q == S_LOAD);
    assign bus.I2C_trigger         = (state_q == S_TRIG);
    assign bus.busy                = (state_q != S_IDLE);
    assign bus.grant_id            = grant_q;

    // Response fields are forced to zero for whichever requester is not being answered.
    assign bus.rsp0_valid   = rspAny && !grant_q;
    assign bus.rsp0_ack     = bus.rsp0_valid && ack_q;
    assign bus.rsp0_rdata   = {8{bus.rsp0_valid}} & rdata_q;
    assign bus.rsp0_timeout = bus.rsp0_valid && tmo_q;
    assign bus.rsp1_valid   = rspAny && grant_q;
    assign bus.rsp1_ack     = bus.rsp1_valid && ack_q;
    assign bus.rsp1_rdata   = {8{bus.rsp1_valid}} & rdata_q;
    assign bus.rsp1_timeout = bus.rsp1_valid && tmo_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: drivers queue expected accepts and responses,
// a negedge monitor pops and compares them as the arbiter presents them.
module tb_i2c_req_arbiter;

    typedef struct {
        bit       id;
        bit       ack;
        bit [7:0] rdata;
        bit       tmo;
        int       cyc;
    } rspExp_t;

    typedef struct {
        bit        id;
        bit [23:0] cmd;
        int        cyc;
    } accExp_t;

    logic clk = 1'b0;
    logic reset;
    int   cycleCnt = 0;
    int   checks = 0;
    int   fails = 0;
    bit   monOn = 1'b0;
    int   trigExp = -1;

    rspExp_t rspQ[$];
    accExp_t accQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    i2c_req_arbiter_if bus ();

    i2c_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stopRun(input string why);
        checks++;
        fails++;
        $display("[TB] FAIL %s: bound expired before the expected event", why);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    endtask

    task automatic waitCycle(input int c);
        while (cycleCnt < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raises valid, waits for the handshake and queues the expected accept.
    task automatic applyStimulus(input bit id, input bit [23:0] cmd, output int hsCyc);
        int budget;
        budget = 0;
        hsCyc  = -1;
        if (id) begin
            bus.req1_cmd = cmd; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_cmd = cmd; bus.req0_valid = 1'b1;
        end
        while (hsCyc < 0 && budget < 50) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) hsCyc = cycleCnt;
            budget++;
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (hsCyc < 0) stopRun("handshake");
        accQ.push_back('{id: id, cmd: cmd, cyc: hsCyc});
    endtask

    task automatic pulseAck(input int c, input bit ack);
        waitCycle(c);
        bus.valid_data_ack       = ack;
        bus.valid_data_ack_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_data_ack_valid = 1'b0;
        bus.valid_data_ack       = 1'b0;
    endtask

    task automatic pulseRd(input int c, input bit [7:0] d);
        waitCycle(c);
        bus.rdata_out       = d;
        bus.rdata_out_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rdata_out_valid = 1'b0;
        bus.rdata_out       = 8'h00;
    endtask

    task automatic waitTrig(output int tc);
        int budget;
        budget = 0;
        tc     = -1;
        while (tc < 0 && budget < 40) begin
            @(negedge clk);
            if (bus.I2C_trigger) tc = cycleCnt;
            budget++;
        end
        if (tc < 0) stopRun("trigger");
    endtask

    // Monitor: every response and every LOAD strobe is matched against the queues.
    always @(negedge clk) begin
        logic       v, a, t;
        logic [7:0] d;
        rspExp_t    e;
        accExp_t    q;
        if (monOn) begin
            for (int n = 0; n < 2; n++) begin
                v = (n == 1) ? bus.rsp1_valid   : bus.rsp0_valid;
                a = (n == 1) ? bus.rsp1_ack     : bus.rsp0_ack;
                d = (n == 1) ? bus.rsp1_rdata   : bus.rsp0_rdata;
                t = (n == 1) ? bus.rsp1_timeout : bus.rsp0_timeout;
                if (v) begin
                    if (rspQ.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL rspUnexpected: got rsp%0d_valid=1 at cycle %0d, expected none", n, cycleCnt);
                    end else begin
                        e = rspQ.pop_front();
                        checkOutput("rspId", 32'(n), 32'(e.id));
                        checkOutput($sformatf("rsp%0d_ack", n), 32'(a), 32'(e.ack));
                        checkOutput($sformatf("rsp%0d_rdata", n), 32'(d), 32'(e.rdata));
                        checkOutput($sformatf("rsp%0d_timeout", n), 32'(t), 32'(e.tmo));
                        if (e.cyc >= 0) checkOutput("rspCycle", cycleCnt, e.cyc);
                    end
                end else begin
                    checkOutput($sformatf("rsp%0d_idleZero", n), {23'h0, a, d}, 32'(t));
                end
            end
            if (bus.valid_addr_data_out) begin
                if (accQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL accUnexpected: got valid_addr_data_out at cycle %0d, expected none", cycleCnt);
                end else begin
                    q = accQ.pop_front();
                    checkOutput("grantId", 32'(bus.grant_id), 32'(q.id));
                    checkOutput("addrDataOut", 32'(bus.addr_data_out), 32'(q.cmd));
                    if (q.cyc >= 0) checkOutput("loadCycle", cycleCnt, q.cyc + 1);
                end
                trigExp = cycleCnt + 1;
            end
            if (bus.I2C_trigger) checkOutput("trigCycle", cycleCnt, trigExp);
        end
    end

    initial begin
        #200000;
        stopRun("watchdog");
    end

    initial begin
        int t, tc, c;
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_cmd = 24'hA0_00_01;
        bus.req1_valid = 1'b0; bus.req1_cmd = 24'h0;
        bus.valid_data_ack = 1'b0; bus.valid_data_ack_valid = 1'b0;
        bus.rdata_out = 8'h00; bus.rdata_out_valid = 1'b0;
        bus.PENDING_WR = 1'b0; bus.PENDING_RD = 1'b0;
        @(posedge clk);
        #1;
        monOn = 1'b1;
        @(negedge clk);
        checkOutput("readyInReset", 32'(bus.req0_ready), 0);
        checkOutput("resetBusy", 32'(bus.busy), 0);
        checkOutput("resetGrant", 32'(bus.grant_id), 0);
        checkOutput("resetAddr", 32'(bus.addr_data_out), 0);
        checkOutput("resetStrobes", {30'h0, bus.valid_addr_data_out, bus.I2C_trigger}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req0_valid = 1'b0;

        // Single write, ack on the fourth WAIT cycle.
        applyStimulus(1'b0, 24'hA0_10_5A, t);
        rspQ.push_back('{id: 1'b0, ack: 1'b1, rdata: 8'h00, tmo: 1'b0, cyc: t + 7});
        pulseAck(t + 6, 1'b1);
        waitCycle(t + 9);

        // Read on requester 1.
        applyStimulus(1'b1, 24'hA1_20_00, t);
        rspQ.push_back('{id: 1'b1, ack: 1'b1, rdata: 8'h3C, tmo: 1'b0, cyc: t + 5});
        pulseRd(t + 4, 8'h3C);
        waitCycle(t + 8);

        // Tie after reset: grants alternate starting with requester 0.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req0_cmd = 24'hA0_30_11;
        bus.req1_cmd = 24'hA1_40_00;
        for (int i = 0; i < 4; i++) begin
            accQ.push_back('{id: 1'(i % 2), cmd: (i % 2 == 1) ? 24'hA1_40_00 : 24'hA0_30_11, cyc: -1});
            rspQ.push_back('{id: 1'(i % 2), ack: 1'b1, rdata: (i % 2 == 1) ? 8'h55 : 8'h00, tmo: 1'b0, cyc: -1});
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitTrig(tc);
            if (i == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            if (i % 2 == 1) pulseRd(tc + 2, 8'h55);
            else pulseAck(tc + 2, 1'b1);
        end
        waitCycle(cycleCnt + 4);

        // Bridge busy holds off all readiness.
        bus.PENDING_RD = 1'b1;
        bus.req0_cmd = 24'hA0_31_22;
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("readyWhilePending", 32'(bus.req0_ready), 0);
            checkOutput("busyWhilePending", 32'(bus.busy), 0);
        end
        @(posedge clk);
        #1;
        bus.PENDING_RD = 1'b0;
        c = cycleCnt;
        applyStimulus(1'b0, 24'hA0_31_22, t);
        checkOutput("readyAfterPending", t, c);
        rspQ.push_back('{id: 1'b0, ack: 1'b1, rdata: 8'h00, tmo: 1'b0, cyc: t + 4});
        pulseAck(t + 3, 1'b1);
        waitCycle(t + 6);

        // Timeout with no completion.
        applyStimulus(1'b0, 24'hA0_50_77, t);
        rspQ.push_back('{id: 1'b0, ack: 1'b0, rdata: 8'h00, tmo: 1'b1, cyc: t + 11});
        waitCycle(t + 13);

        // Completion on the final count cycle beats the timeout.
        applyStimulus(1'b0, 24'hA0_51_78, t);
        rspQ.push_back('{id: 1'b0, ack: 1'b1, rdata: 8'h00, tmo: 1'b0, cyc: t + 11});
        pulseAck(t + 10, 1'b1);
        waitCycle(t + 13);

        // Read NACK.
        applyStimulus(1'b1, 24'hA1_60_00, t);
        bus.rdata_out = 8'h99;
        rspQ.push_back('{id: 1'b1, ack: 1'b0, rdata: 8'h00, tmo: 1'b0, cyc: t + 5});
        pulseAck(t + 4, 1'b0);
        waitCycle(t + 7);

        // Positive ack during a read is ignored; data completes it later.
        applyStimulus(1'b1, 24'hA1_61_00, t);
        rspQ.push_back('{id: 1'b1, ack: 1'b1, rdata: 8'h42, tmo: 1'b0, cyc: t + 6});
        pulseAck(t + 3, 1'b1);
        pulseRd(t + 5, 8'h42);
        waitCycle(t + 8);

        // Stray bridge completions in IDLE must neither respond nor be remembered.
        pulseRd(cycleCnt + 1, 8'hEE);
        pulseAck(cycleCnt + 1, 1'b0);
        waitCycle(cycleCnt + 6);
        applyStimulus(1'b0, 24'hA0_62_33, t);
        rspQ.push_back('{id: 1'b0, ack: 1'b1, rdata: 8'h00, tmo: 1'b0, cyc: t + 6});
        pulseAck(t + 5, 1'b1);
        waitCycle(t + 8);

        // Reset during WAIT drops the transaction and restores req0 priority.
        applyStimulus(1'b1, 24'hA1_70_00, t);
        waitCycle(t + 4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("busyAfterReset", 32'(bus.busy), 0);
        waitCycle(cycleCnt + 12);
        bus.req0_cmd = 24'hA0_71_44;
        bus.req1_cmd = 24'hA1_72_00;
        accQ.push_back('{id: 1'b0, cmd: 24'hA0_71_44, cyc: -1});
        rspQ.push_back('{id: 1'b0, ack: 1'b1, rdata: 8'h00, tmo: 1'b0, cyc: -1});
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        waitTrig(tc);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        pulseAck(tc + 1, 1'b1);
        waitCycle(cycleCnt + 8);

        checkOutput("rspQueueDrained", 32'(rspQ.size()), 0);
        checkOutput("accQueueDrained", 32'(accQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
